// File: rtl/vec_pair_sched_if.sv
// Beat stream from the pair scheduler to the vector-fetch/distance stage.
// Master drives m_valid plus the beat payload; slave drives m_ready.
// Payload: image index, lane-0 library index, lane mask, row/frame markers.
interface vec_pair_sched_if #(
   parameter int IMG_AW = 10,
   parameter int LIB_AW = 12,
   parameter int LANES  = 4
);
   logic              m_valid;
   logic              m_ready;
   logic [IMG_AW-1:0] m_img_addr;
   logic [LIB_AW-1:0] m_lib_addr;
   logic [LANES-1:0]  m_lane_mask;
   logic              m_row_last;
   logic              m_frame_last;

   modport master (
      output m_valid, m_img_addr, m_lib_addr, m_lane_mask, m_row_last, m_frame_last,
      input  m_ready
   );

   modport slave (
      input  m_valid, m_img_addr, m_lib_addr, m_lane_mask, m_row_last, m_frame_last,
      output m_ready
   );
endinterface

// File: rtl/vec_pair_sched.sv
// Purpose: walks image vectors (outer) x library vectors (inner), LANES library vectors per beat.
// Latency: start at cycle T -> first beat valid at T+1; done/aborted/cfg_err pulse 1 cycle after cause.
// Backpressure: beat and markers held stable while m_valid & !m_ready; 1 beat/cycle when ready.
//
// Ports: clk, rst_n (async active-low); start/abort control; cfg_img_num/cfg_lib_num job counts
// (latched at start); busy/done/aborted/cfg_err status; m = beat stream (master modport).
module vec_pair_sched #(
   parameter int  IMG_VEC_MAX = 1024,
   parameter int  LIB_VEC_MAX = 4096,
   parameter int  LANES       = 4,
   localparam int IMG_AW      = $clog2(IMG_VEC_MAX),
   localparam int LIB_AW      = $clog2(LIB_VEC_MAX)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [IMG_AW:0]  cfg_img_num,
   input  logic [LIB_AW:0]  cfg_lib_num,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic             cfg_err,
   vec_pair_sched_if.master m
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [LIB_AW:0] LANES_W   = (LIB_AW+1)'(LANES);
   localparam logic [LIB_AW:0] LIB_MAX_W = (LIB_AW+1)'(LIB_VEC_MAX);
   localparam logic [IMG_AW:0] IMG_MAX_W = (IMG_AW+1)'(IMG_VEC_MAX);

   state_t            state_q, state_d;
   logic [IMG_AW:0]   img_num_q, img_num_d;
   logic [LIB_AW:0]   lib_num_q, lib_num_d;
   logic              valid_q, valid_d;
   logic [IMG_AW-1:0] img_q, img_d;
   logic [LIB_AW-1:0] lib_q, lib_d;
   logic [LANES-1:0]  mask_q, mask_d;
   logic              row_q, row_d;
   logic              frame_q, frame_d;
   logic              done_d, aborted_d, cfg_err_d;

   // Beat being loaded into the output registers and the counts it is decoded against.
   logic              load, clear;
   logic [IMG_AW-1:0] ld_img;
   logic [LIB_AW-1:0] ld_lib;
   logic [IMG_AW:0]   ld_img_num;
   logic [LIB_AW:0]   ld_lib_num;
   logic              ld_row, ld_frame;
   logic [LANES-1:0]  ld_mask;

   logic              cfg_ok;
   logic              xfer;

   assign cfg_ok = (cfg_img_num != '0) && (cfg_img_num <= IMG_MAX_W) &&
                   (cfg_lib_num != '0) && (cfg_lib_num <= LIB_MAX_W);
   assign xfer   = valid_q & m.m_ready;

   always_comb begin
      state_d    = state_q;
      img_num_d  = img_num_q;
      lib_num_d  = lib_num_q;
      valid_d    = valid_q;
      img_d      = img_q;
      lib_d      = lib_q;
      mask_d     = mask_q;
      row_d      = row_q;
      frame_d    = frame_q;
      done_d     = 1'b0;
      aborted_d  = 1'b0;
      cfg_err_d  = 1'b0;
      load       = 1'b0;
      clear      = 1'b0;
      ld_img     = '0;
      ld_lib     = '0;
      ld_img_num = img_num_q;
      ld_lib_num = lib_num_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (cfg_ok) begin
                  state_d    = RUN;
                  img_num_d  = cfg_img_num;
                  lib_num_d  = cfg_lib_num;
                  ld_img_num = cfg_img_num;
                  ld_lib_num = cfg_lib_num;
                  load       = 1'b1;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         RUN: begin
            // Abort wins over a same-cycle handshake: that beat is treated as not taken.
            if (abort) begin
               state_d   = IDLE;
               aborted_d = 1'b1;
               clear     = 1'b1;
            end else if (xfer) begin
               if (frame_q) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                  clear   = 1'b1;
               end else if (row_q) begin
                  load   = 1'b1;
                  ld_img = img_q + 1'b1;
                  ld_lib = '0;
               end else begin
                  load   = 1'b1;
                  ld_img = img_q;
                  ld_lib = lib_q + LIB_AW'(LANES);
               end
            end
         end
         default: begin
            state_d = IDLE;
            clear   = 1'b1;
         end
      endcase

      // Markers and mask are decoded one cycle early so they leave the block registered.
      // Compares use one extra bit so lib_num == LIB_VEC_MAX never wraps.
      ld_row   = ({1'b0, ld_lib} + LANES_W) >= ld_lib_num;
      ld_frame = ld_row && ({1'b0, ld_img} == (ld_img_num - (IMG_AW+1)'(1)));
      for (int i = 0; i < LANES; i++) begin
         ld_mask[i] = ({1'b0, ld_lib} + (LIB_AW+1)'(i)) < ld_lib_num;
      end

      if (load) begin
         valid_d = 1'b1;
         img_d   = ld_img;
         lib_d   = ld_lib;
         mask_d  = ld_mask;
         row_d   = ld_row;
         frame_d = ld_frame;
      end else if (clear) begin
         valid_d = 1'b0;
         img_d   = '0;
         lib_d   = '0;
         mask_d  = '0;
         row_d   = 1'b0;
         frame_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         img_num_q <= '0;
         lib_num_q <= '0;
         valid_q   <= 1'b0;
         img_q     <= '0;
         lib_q     <= '0;
         mask_q    <= '0;
         row_q     <= 1'b0;
         frame_q   <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         state_q   <= state_d;
         img_num_q <= img_num_d;
         lib_num_q <= lib_num_d;
         valid_q   <= valid_d;
         img_q     <= img_d;
         lib_q     <= lib_d;
         mask_q    <= mask_d;
         row_q     <= row_d;
         frame_q   <= frame_d;
         done      <= done_d;
         aborted   <= aborted_d;
         cfg_err   <= cfg_err_d;
      end
   end

   assign busy           = (state_q == RUN);
   assign m.m_valid      = valid_q;
   assign m.m_img_addr   = img_q;
   assign m.m_lib_addr   = lib_q;
   assign m.m_lane_mask  = mask_q;
   assign m.m_row_last   = row_q;
   assign m.m_frame_last = frame_q;

endmodule

// File: tb/tb_vec_pair_sched.sv
// Bench for vec_pair_sched: main instance at default sizes (LANES=4) and a small instance
// (4 x 16, LANES=1) so the maximum-count job fits in a short run.
// Expected beats come from a nested-loop model of the image x library walk.
module tb_vec_pair_sched;
   localparam int A_IAW = 10, A_LAW = 12, A_LANES = 4;
   localparam int B_IAW = 2,  B_LAW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic              start_a = 1'b0, abort_a = 1'b0;
   logic [A_IAW:0]    cfg_img_a = '0;
   logic [A_LAW:0]    cfg_lib_a = '0;
   logic              busy_a, done_a, aborted_a, cfg_err_a;
   logic              start_b = 1'b0, abort_b = 1'b0;
   logic [B_IAW:0]    cfg_img_b = '0;
   logic [B_LAW:0]    cfg_lib_b = '0;
   logic              busy_b, done_b, aborted_b, cfg_err_b;

   vec_pair_sched_if #(.IMG_AW(A_IAW), .LIB_AW(A_LAW), .LANES(A_LANES)) ia();
   vec_pair_sched_if #(.IMG_AW(B_IAW), .LIB_AW(B_LAW), .LANES(1))       ib();

   vec_pair_sched #(.IMG_VEC_MAX(1024), .LIB_VEC_MAX(4096), .LANES(A_LANES)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
      .cfg_img_num(cfg_img_a), .cfg_lib_num(cfg_lib_a),
      .busy(busy_a), .done(done_a), .aborted(aborted_a), .cfg_err(cfg_err_a), .m(ia));

   vec_pair_sched #(.IMG_VEC_MAX(4), .LIB_VEC_MAX(16), .LANES(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
      .cfg_img_num(cfg_img_b), .cfg_lib_num(cfg_lib_b),
      .busy(busy_b), .done(done_b), .aborted(aborted_b), .cfg_err(cfg_err_b), .m(ib));

   // Event counters for the main instance (a beat under abort is not a transfer).
   int n_xfer_a = 0, n_done_a = 0, n_abort_a = 0;
   always @(posedge clk) begin
      if (ia.m_valid && ia.m_ready && !abort_a) n_xfer_a <= n_xfer_a + 1;
      if (done_a)    n_done_a  <= n_done_a + 1;
      if (aborted_a) n_abort_a <= n_abort_a + 1;
   end

   typedef struct {
      int         img;
      int         lib;
      logic [3:0] mask;
      bit         row;
      bit         frame;
   } beat_t;
   beat_t exp_q[$];

   task automatic build_model(input int img_num, input int lib_num, input int lanes);
      int    nb;
      beat_t b;
      exp_q.delete();
      nb = (lib_num + lanes - 1) / lanes;
      for (int i = 0; i < img_num; i++) begin
         for (int k = 0; k < nb; k++) begin
            b.img  = i;
            b.lib  = k * lanes;
            b.mask = '0;
            for (int l = 0; l < lanes; l++) if (b.lib + l < lib_num) b.mask[l] = 1'b1;
            b.row   = (k == nb - 1);
            b.frame = b.row && (i == img_num - 1);
            exp_q.push_back(b);
         end
      end
   endtask

   // Called at a negedge; start is raised immediately, returns at the negedge where done is high.
   task automatic run_job_a(input int img, input int lib, input bit rnd);
      int    x0, cyc, nbeats;
      bit    rdy;
      beat_t e;
      build_model(img, lib, A_LANES);
      nbeats    = exp_q.size();
      x0        = n_xfer_a;
      cfg_img_a = (A_IAW+1)'(img);
      cfg_lib_a = (A_LAW+1)'(lib);
      start_a   = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      checks++;
      if (busy_a !== 1'b1) begin
         errors++;
         $display("FAIL job_busy img=%0d lib=%0d busy=%b required 1", img, lib, busy_a);
      end
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 4000) begin
         e = exp_q[0];
         checks++;
         if (ia.m_valid !== 1'b1 || ia.m_img_addr !== A_IAW'(e.img) ||
             ia.m_lib_addr !== A_LAW'(e.lib) || ia.m_lane_mask !== e.mask ||
             ia.m_row_last !== e.row || ia.m_frame_last !== e.frame || done_a !== 1'b0) begin
            errors++;
            $display("FAIL beat got v=%b img=%0d lib=%0d mask=%b row=%b frame=%b done=%b required v=1 img=%0d lib=%0d mask=%b row=%b frame=%b done=0",
                     ia.m_valid, ia.m_img_addr, ia.m_lib_addr, ia.m_lane_mask, ia.m_row_last,
                     ia.m_frame_last, done_a, e.img, e.lib, e.mask, e.row, e.frame);
         end
         rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         ia.m_ready = rdy;
         @(negedge clk);
         if (rdy) e = exp_q.pop_front();
         cyc++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL job_timeout beats_left=%0d required 0", exp_q.size());
      end
      checks++;
      if ({ia.m_valid, busy_a, done_a, ia.m_img_addr, ia.m_lib_addr, ia.m_lane_mask,
           ia.m_row_last, ia.m_frame_last} !== {3'b001, 28'd0}) begin
         errors++;
         $display("FAIL job_end v=%b busy=%b done=%b img=%0d lib=%0d mask=%b row=%b frame=%b required v=0 busy=0 done=1 rest 0",
                  ia.m_valid, busy_a, done_a, ia.m_img_addr, ia.m_lib_addr, ia.m_lane_mask,
                  ia.m_row_last, ia.m_frame_last);
      end
      checks++;
      if (n_xfer_a - x0 != img * ((lib + A_LANES - 1) / A_LANES)) begin
         errors++;
         $display("FAIL xfer_count got %0d required %0d", n_xfer_a - x0, nbeats);
      end
   endtask

   task automatic check_done_once(input int d0, input int want);
      @(negedge clk);
      checks++;
      if (done_a !== 1'b0 || n_done_a - d0 != want) begin
         errors++;
         $display("FAIL done_pulse done=%b pulses=%0d required done=0 pulses=%0d", done_a, n_done_a - d0, want);
      end
   endtask

   task automatic test_reset;
      ia.m_ready = 1'b0;
      ib.m_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy_a, done_a, aborted_a, cfg_err_a, ia.m_valid, ia.m_img_addr, ia.m_lib_addr,
           ia.m_lane_mask, ia.m_row_last, ia.m_frame_last,
           busy_b, done_b, aborted_b, cfg_err_b, ib.m_valid, ib.m_img_addr, ib.m_lib_addr,
           ib.m_lane_mask, ib.m_row_last, ib.m_frame_last} !== '0) begin
         errors++;
         $display("FAIL reset_outputs busy=%b v=%b img=%0d lib=%0d required all 0", busy_a, ia.m_valid, ia.m_img_addr, ia.m_lib_addr);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy_a !== 1'b0 || ia.m_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle busy=%b v=%b required 0 0", busy_a, ia.m_valid);
      end
   endtask

   task automatic test_basic;
      int d0;
      d0 = n_done_a;
      run_job_a(2, 8, 1'b0);
      check_done_once(d0, 1);
      d0 = n_done_a;
      run_job_a(1, 6, 1'b0);
      check_done_once(d0, 1);
   endtask

   task automatic test_backpressure;
      int d0, img, lib;
      d0 = n_done_a;
      run_job_a(3, 5, 1'b1);
      check_done_once(d0, 1);
      for (int j = 0; j < 4; j++) begin
         img = $urandom_range(1, 4);
         lib = $urandom_range(1, 23);
         d0  = n_done_a;
         run_job_a(img, lib, 1'b1);
         check_done_once(d0, 1);
      end
   endtask

   task automatic test_back_to_back;
      int d0;
      d0 = n_done_a;
      run_job_a(2, 3, 1'b0);
      run_job_a(1, 9, 1'b0);
      check_done_once(d0, 2);
   endtask

   task automatic test_abort;
      int d0, a0;
      d0 = n_done_a;
      a0 = n_abort_a;
      cfg_img_a  = 11'd3;
      cfg_lib_a  = 13'd8;
      ia.m_ready = 1'b1;
      start_a    = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      @(negedge clk);
      checks++;
      if (ia.m_valid !== 1'b1 || ia.m_lib_addr !== 12'd4 || ia.m_img_addr !== 10'd0) begin
         errors++;
         $display("FAIL abort_second_beat v=%b img=%0d lib=%0d required v=1 img=0 lib=4", ia.m_valid, ia.m_img_addr, ia.m_lib_addr);
      end
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      checks++;
      if ({ia.m_valid, busy_a, aborted_a, done_a, ia.m_img_addr, ia.m_lib_addr, ia.m_lane_mask,
           ia.m_row_last, ia.m_frame_last} !== {4'b0010, 28'd0}) begin
         errors++;
         $display("FAIL abort_state v=%b busy=%b aborted=%b done=%b lib=%0d required v=0 busy=0 aborted=1 done=0 lib=0",
                  ia.m_valid, busy_a, aborted_a, done_a, ia.m_lib_addr);
      end
      @(negedge clk);
      checks++;
      if (aborted_a !== 1'b0 || n_abort_a - a0 != 1 || n_done_a != d0 || ia.m_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_pulse aborted=%b pulses=%0d dones=%0d v=%b required 0 1 0 0",
                  aborted_a, n_abort_a - a0, n_done_a - d0, ia.m_valid);
      end
      run_job_a(1, 1, 1'b0);
      check_done_once(d0, 1);
   endtask

   task automatic test_cfg_err;
      int         imgs[3] = '{1, 1025, 1};
      int         libs[3] = '{0, 4, 4097};
      int         x0, d0;
      for (int j = 0; j < 3; j++) begin
         cfg_img_a = 11'(imgs[j]);
         cfg_lib_a = 13'(libs[j]);
         start_a   = 1'b1;
         @(negedge clk);
         start_a = 1'b0;
         checks++;
         if (cfg_err_a !== 1'b1 || busy_a !== 1'b0 || ia.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err img=%0d lib=%0d err=%b busy=%b v=%b required 1 0 0", imgs[j], libs[j], cfg_err_a, busy_a, ia.m_valid);
         end
         @(negedge clk);
         checks++;
         if (cfg_err_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_pulse err=%b busy=%b required 0 0", cfg_err_a, busy_a);
         end
      end
      // start while busy must not restart or reconfigure the running job
      x0 = n_xfer_a;
      d0 = n_done_a;
      ia.m_ready = 1'b0;
      cfg_img_a  = 11'd2;
      cfg_lib_a  = 13'd4;
      start_a    = 1'b1;
      @(negedge clk);
      cfg_img_a = 11'd1;
      cfg_lib_a = 13'd1;
      @(negedge clk);
      start_a = 1'b0;
      checks++;
      if (ia.m_valid !== 1'b1 || ia.m_img_addr !== 10'd0 || ia.m_lib_addr !== 12'd0 ||
          ia.m_lane_mask !== 4'b1111 || ia.m_row_last !== 1'b1 || ia.m_frame_last !== 1'b0) begin
         errors++;
         $display("FAIL busy_start_stall v=%b img=%0d mask=%b row=%b frame=%b required 1 0 1111 1 0",
                  ia.m_valid, ia.m_img_addr, ia.m_lane_mask, ia.m_row_last, ia.m_frame_last);
      end
      ia.m_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (ia.m_valid !== 1'b1 || ia.m_img_addr !== 10'd1 || ia.m_frame_last !== 1'b1) begin
         errors++;
         $display("FAIL busy_start_beat2 v=%b img=%0d frame=%b required 1 1 1", ia.m_valid, ia.m_img_addr, ia.m_frame_last);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (ia.m_valid !== 1'b0 || busy_a !== 1'b0 || n_xfer_a - x0 != 2 || n_done_a - d0 != 1) begin
         errors++;
         $display("FAIL busy_start_job v=%b busy=%b xfers=%0d dones=%0d required 0 0 2 1",
                  ia.m_valid, busy_a, n_xfer_a - x0, n_done_a - d0);
      end
   endtask

   task automatic test_max_and_reset;
      ib.m_ready = 1'b1;
      cfg_img_b  = 3'd4;
      cfg_lib_b  = 5'd16;
      start_b    = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 16; k++) begin
            checks++;
            if (ib.m_valid !== 1'b1 || ib.m_img_addr !== 2'(i) || ib.m_lib_addr !== 4'(k) ||
                ib.m_lane_mask !== 1'b1 || ib.m_row_last !== (k == 15) ||
                ib.m_frame_last !== (k == 15 && i == 3)) begin
               errors++;
               $display("FAIL max_beat got v=%b img=%0d lib=%0d row=%b frame=%b required v=1 img=%0d lib=%0d",
                        ib.m_valid, ib.m_img_addr, ib.m_lib_addr, ib.m_row_last, ib.m_frame_last, i, k);
            end
            @(negedge clk);
         end
      end
      checks++;
      if (done_b !== 1'b1 || ib.m_valid !== 1'b0 || busy_b !== 1'b0) begin
         errors++;
         $display("FAIL max_done done=%b v=%b busy=%b required 1 0 0", done_b, ib.m_valid, busy_b);
      end
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (busy_b !== 1'b1 || ib.m_lib_addr !== 4'd5) begin
         errors++;
         $display("FAIL mid_job busy=%b lib=%0d required 1 5", busy_b, ib.m_lib_addr);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy_b, done_b, aborted_b, cfg_err_b, ib.m_valid, ib.m_img_addr, ib.m_lib_addr,
           ib.m_lane_mask, ib.m_row_last, ib.m_frame_last} !== '0) begin
         errors++;
         $display("FAIL async_reset busy=%b v=%b img=%0d lib=%0d required all 0", busy_b, ib.m_valid, ib.m_img_addr, ib.m_lib_addr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (busy_b !== 1'b0 || done_b !== 1'b0 || aborted_b !== 1'b0 || ib.m_valid !== 1'b0) begin
         errors++;
         $display("FAIL after_reset busy=%b done=%b aborted=%b v=%b required 0 0 0 0", busy_b, done_b, aborted_b, ib.m_valid);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_backpressure;
      test_back_to_back;
      test_abort;
      test_cfg_err;
      test_max_and_reset;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
